// File: rtl/icache_refill.sv
// icache_refill: instruction-cache miss refill engine, one 4-word burst per miss into the CAM.
// Optional ICACHE_REFILL_CWF_EN: the burst starts at the missed word (critical-word-first).
module icache_refill #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_core,
    input  logic        reset,
    input  logic        miss_req,
    input  logic [26:0] miss_paddr,
    input  logic        miss_lru_way,
    input  logic [1:0]  miss_flags,
    output logic        miss_busy,
    output logic        miss_done,
    output logic        miss_err,
    output logic [31:0] miss_data,
    output logic        bus_req,
    output logic [26:0] bus_addr,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rerr,
    output logic        cam_write_req,
    output logic        cam_write_lru_way,
    output logic [1:0]  cam_write_offset,
    output logic [31:0] cam_write_data,
    output logic [16:0] cam_write_tag,
    output logic [1:0]  cam_write_flags,
    output logic        cam_lru_update
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_e;

    typedef struct packed {
        logic [26:0] paddr;
        logic        lru_way;
        logic [1:0]  flags;
    } miss_t;

    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    miss_t       miss_q, miss_d;
    logic [1:0]  beat_q, beat_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;

    logic [1:0]  start_off, beat_off;
    logic [26:0] burst_addr;
    logic        beat_fire, last_beat, bus_event, wdog_active, wdog_expire;

`ifdef ICACHE_REFILL_CWF_EN
    assign start_off  = miss_q.paddr[1:0];
    assign burst_addr = miss_q.paddr;
`else
    assign start_off  = 2'b00;
    assign burst_addr = {miss_q.paddr[26:2], 2'b00};
`endif

    // 2-bit add wraps the offset within the 4-word line
    assign beat_off    = start_off + beat_q;
    assign beat_fire   = (state_q == S_DATA) && bus_rvalid;
    assign last_beat   = beat_fire && (beat_q == 2'd3);
    assign wdog_active = (state_q == S_REQ) || (state_q == S_DATA);
    assign bus_event   = ((state_q == S_REQ) && bus_gnt) || beat_fire;
    assign wdog_expire = (TIMEOUT != 8'd0) && wdog_active && !bus_event
                         && (wdog_q == TIMEOUT - 8'd1);

    always_ff @(posedge clk_core) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (miss_req) state_d = S_REQ;
            S_REQ: begin
                if (bus_gnt)          state_d = S_DATA;
                else if (wdog_expire) state_d = S_DONE;
            end
            S_DATA: begin
                if (last_beat)        state_d = S_DONE;
                else if (wdog_expire) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        miss_d = miss_q;
        beat_d = beat_q;
        wdog_d = wdog_q;
        err_d  = err_q;
        data_d = data_q;
        if (state_q == S_IDLE) begin
            if (miss_req) begin
                miss_d.paddr   = miss_paddr;
                miss_d.lru_way = miss_lru_way;
                miss_d.flags   = miss_flags;
                beat_d         = '0;
                wdog_d         = '0;
                err_d          = 1'b0;
                data_d         = '0;
            end
        end else if (wdog_active) begin
            // saturate so a disabled watchdog never wraps into a false match
            if (bus_event)              wdog_d = '0;
            else if (wdog_q != 8'hFF)   wdog_d = wdog_q + 8'd1;
            if (wdog_expire) err_d = 1'b1;
            if (beat_fire) begin
                beat_d = beat_q + 2'd1;
                if (bus_rerr) err_d = 1'b1;
                if (beat_off == miss_q.paddr[1:0]) data_d = bus_rdata;
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            miss_q <= '0;
            beat_q <= '0;
            wdog_q <= '0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            miss_q <= miss_d;
            beat_q <= beat_d;
            wdog_q <= wdog_d;
            err_q  <= err_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        miss_busy         = (state_q != S_IDLE);
        miss_done         = (state_q == S_DONE);
        miss_err          = miss_done && err_q;
        miss_data         = miss_done ? data_q : '0;
        bus_req           = (state_q == S_REQ);
        bus_addr          = bus_req ? burst_addr : '0;
        cam_write_req     = beat_fire;
        cam_write_lru_way = 1'b0;
        cam_write_offset  = '0;
        cam_write_data    = '0;
        cam_write_tag     = '0;
        cam_write_flags   = '0;
        cam_lru_update    = miss_done && !err_q;
        if (beat_fire) begin
            cam_write_lru_way = miss_q.lru_way;
            cam_write_offset  = beat_off;
            cam_write_data    = bus_rdata;
            cam_write_tag     = miss_q.paddr[26:10];
            // the line becomes valid only via a clean final beat
            if (last_beat && !err_q && !bus_rerr) cam_write_flags = miss_q.flags;
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: scheduled bus responses checked against a timeline model of the refill.
module tb_icache_refill;

    logic clk_core = 1'b0;
    logic reset;
    always #5 clk_core = ~clk_core;

`ifdef ICACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic [1:0]        miss_req, bus_gnt, bus_rvalid, bus_rerr;
    logic [26:0]       miss_paddr;
    logic              miss_lru_way;
    logic [1:0]        miss_flags;
    logic [31:0]       bus_rdata;
    logic [1:0]        miss_busy, miss_done, miss_err, bus_req;
    logic [1:0]        cam_write_req, cam_write_lru_way, cam_lru_update;
    logic [1:0][31:0]  miss_data, cam_write_data;
    logic [1:0][26:0]  bus_addr;
    logic [1:0][1:0]   cam_write_offset, cam_write_flags;
    logic [1:0][16:0]  cam_write_tag;

    int checks = 0;
    int errors = 0;

    // instance 0: default watchdog (255); instance 1: short watchdog (4)
    for (genvar g = 0; g < 2; g++) begin : g_dut
        icache_refill #(.TIMEOUT_CYCLES(g == 0 ? 255 : 4)) u_dut (
            .clk_core          (clk_core),
            .reset             (reset),
            .miss_req          (miss_req[g]),
            .miss_paddr        (miss_paddr),
            .miss_lru_way      (miss_lru_way),
            .miss_flags        (miss_flags),
            .miss_busy         (miss_busy[g]),
            .miss_done         (miss_done[g]),
            .miss_err          (miss_err[g]),
            .miss_data         (miss_data[g]),
            .bus_req           (bus_req[g]),
            .bus_addr          (bus_addr[g]),
            .bus_gnt           (bus_gnt[g]),
            .bus_rvalid        (bus_rvalid[g]),
            .bus_rdata         (bus_rdata),
            .bus_rerr          (bus_rerr[g]),
            .cam_write_req     (cam_write_req[g]),
            .cam_write_lru_way (cam_write_lru_way[g]),
            .cam_write_offset  (cam_write_offset[g]),
            .cam_write_data    (cam_write_data[g]),
            .cam_write_tag     (cam_write_tag[g]),
            .cam_write_flags   (cam_write_flags[g]),
            .cam_lru_update    (cam_lru_update[g])
        );
    end

    function automatic logic [118:0] outs(input int s);
        return {miss_busy[s], miss_done[s], miss_err[s], miss_data[s], bus_req[s], bus_addr[s],
                cam_write_req[s], cam_write_lru_way[s], cam_write_offset[s], cam_write_data[s],
                cam_write_tag[s], cam_write_flags[s], cam_lru_update[s]};
    endfunction

    // One refill. The caller is positioned just after a rising edge; cycle 0 carries miss_req.
    // gaps[4i+:4] = idle cycles before beat i; beat 0 is due the cycle after the grant.
    task automatic run_refill(input string name, input int sel, input logic [26:0] paddr,
                              input logic way, input logic [1:0] flg, input int gnt_dly,
                              input logic [15:0] gaps, input int nbeats, input int err_beat,
                              input bit spur, input bit extra_req);
        int          tmo = (sel == 0) ? 255 : 4;
        int          g_c = 1 + gnt_dly;
        int          sb[4];
        logic [31:0] bd[4];
        int          done_c, nwr, t;
        bit          err, req_to;
        logic [1:0]  start, kk;
        logic [26:0] exp_addr;
        logic [31:0] exp_md;

        t = g_c + 1;
        for (int i = 0; i < 4; i++) begin
            bd[i] = $urandom;
            if (i < nbeats) begin
                sb[i] = t + int'(gaps[4*i +: 4]);
                t = sb[i] + 1;
            end else sb[i] = -1;
        end

        // Reference timeline: which beats land, when DONE comes, whether it errs.
        start    = CWF ? paddr[1:0] : 2'b00;
        exp_addr = CWF ? paddr : {paddr[26:2], 2'b00};
        err = 1'b0; req_to = 1'b0; nwr = 0; done_c = -1;
        if (gnt_dly >= tmo) begin
            req_to = 1'b1; err = 1'b1; done_c = 1 + tmo;
        end else begin
            t = g_c + 1;
            for (int i = 0; i < 4 && done_c < 0; i++) begin
                int idle;
                idle = (i < nbeats) ? sb[i] - t : 1 << 20;
                if (idle >= tmo) begin
                    done_c = t + tmo; err = 1'b1;
                end else begin
                    nwr++;
                    if (i == err_beat) err = 1'b1;
                    t = sb[i] + 1;
                end
            end
            if (done_c < 0) done_c = t;
        end
        kk = paddr[1:0] - start;
        exp_md = bd[kk];

        for (int c = 0; c <= done_c; c++) begin
            int         wi, bi;
            bit         exp_req, exp_wr;
            logic [1:0] eo, ef;
            wi = -1; bi = -1;
            for (int i = 0; i < nbeats; i++) if (sb[i] == c) bi = i;
            for (int i = 0; i < nwr; i++) if (sb[i] == c) wi = i;

            miss_req[sel]   = (c == 0) || (extra_req && c == g_c + 1);
            miss_paddr      = (c == 0) ? paddr : 27'($urandom);
            miss_lru_way    = (c == 0) ? way : 1'($urandom);
            miss_flags      = (c == 0) ? flg : 2'($urandom);
            bus_gnt[sel]    = (c == g_c);
            bus_rvalid[sel] = (bi >= 0) || (spur && c == g_c);
            bus_rdata       = (bi >= 0) ? bd[bi] : $urandom;
            bus_rerr[sel]   = (bi >= 0) ? (bi == err_beat) : 1'($urandom);

            @(negedge clk_core);
            checks++;
            if (miss_busy[sel] !== (c >= 1)) begin
                errors++;
                $display("FAIL %s c=%0d busy: got %b exp %b", name, c, miss_busy[sel], c >= 1);
            end
            exp_req = req_to ? (c >= 1 && c < done_c) : (c >= 1 && c <= g_c);
            checks++;
            if (bus_req[sel] !== exp_req) begin
                errors++;
                $display("FAIL %s c=%0d bus_req: got %b exp %b", name, c, bus_req[sel], exp_req);
            end
            if (exp_req) begin
                checks++;
                if (bus_addr[sel] !== exp_addr) begin
                    errors++;
                    $display("FAIL %s c=%0d bus_addr: got %h exp %h", name, c, bus_addr[sel], exp_addr);
                end
            end
            exp_wr = (wi >= 0);
            checks++;
            if (cam_write_req[sel] !== exp_wr) begin
                errors++;
                $display("FAIL %s c=%0d cam_write_req: got %b exp %b", name, c, cam_write_req[sel], exp_wr);
            end
            if (exp_wr) begin
                eo = start + 2'(wi);
                ef = (wi == 3 && !err) ? flg : 2'b00;
                checks++;
                if ({cam_write_lru_way[sel], cam_write_offset[sel], cam_write_data[sel],
                     cam_write_flags[sel], cam_write_tag[sel]} !== {way, eo, bd[wi], ef, paddr[26:10]}) begin
                    errors++;
                    $display("FAIL %s c=%0d cam_write way/off/data/flags/tag: got %b/%0d/%h/%b/%h exp %b/%0d/%h/%b/%h",
                             name, c, cam_write_lru_way[sel], cam_write_offset[sel], cam_write_data[sel],
                             cam_write_flags[sel], cam_write_tag[sel], way, eo, bd[wi], ef, paddr[26:10]);
                end
            end
            checks++;
            if ({miss_done[sel], cam_lru_update[sel]} !== {c == done_c, c == done_c && !err}) begin
                errors++;
                $display("FAIL %s c=%0d done/lru_update: got %b%b exp %b%b", name, c, miss_done[sel],
                         cam_lru_update[sel], c == done_c, c == done_c && !err);
            end
            if (c == done_c) begin
                checks++;
                if (miss_err[sel] !== err) begin
                    errors++;
                    $display("FAIL %s c=%0d miss_err: got %b exp %b", name, c, miss_err[sel], err);
                end
                if (nwr == 4) begin
                    checks++;
                    if (miss_data[sel] !== exp_md) begin
                        errors++;
                        $display("FAIL %s c=%0d miss_data: got %h exp %h", name, c, miss_data[sel], exp_md);
                    end
                end
            end
            @(posedge clk_core); #1;
        end
        miss_req[sel] = 1'b0; bus_gnt[sel] = 1'b0; bus_rvalid[sel] = 1'b0; bus_rerr[sel] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        miss_req = '0; bus_gnt = '0; bus_rvalid = '0; bus_rerr = '0;
        miss_paddr = '0; miss_lru_way = 1'b0; miss_flags = '0; bus_rdata = '0;
        repeat (2) @(posedge clk_core);
        #1 miss_req[0] = 1'b1;
        @(posedge clk_core); #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (outs(s) !== '0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got %h exp 0", s, outs(s));
            end
        end
        miss_req[0] = 1'b0;
        reset = 1'b0;
        @(posedge clk_core); #1;
    endtask

    task automatic test_basic();
        run_refill("basic", 0, 27'h0123456, 1'b1, 2'b11, 0, 16'h0000, 4, -1, 1'b0, 1'b0);
    endtask

    task automatic test_offset3();
        run_refill("offset3", 0, {27'($urandom) & 27'h7FFFFFC} | 27'd3, 1'b0, 2'b10, 0, 16'h0000, 4, -1, 1'b0, 1'b0);
    endtask

    task automatic test_bus_error();
        run_refill("bus_err_b1", 0, 27'($urandom), 1'b1, 2'b11, 0, 16'h0000, 4, 1, 1'b0, 1'b0);
        run_refill("bus_err_b3", 0, 27'($urandom), 1'b0, 2'b01, 1, 16'h0100, 4, 3, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_refill("stall", 0, 27'($urandom), 1'b1, 2'b11, 5, 16'h3000, 4, -1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_refill("tmo_data", 1, 27'($urandom), 1'b1, 2'b11, 2, 16'h0210, 3, -1, 1'b0, 1'b0);
        run_refill("tmo_edge_ok", 1, 27'($urandom), 1'b0, 2'b11, 3, 16'h3333, 4, -1, 1'b0, 1'b0);
        run_refill("tmo_req", 1, 27'($urandom), 1'b1, 2'b11, 4, 16'h0000, 4, -1, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_req();
        run_refill("busy_req_spur", 0, 27'($urandom), 1'b1, 2'b11, 2, 16'h0101, 4, -1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        miss_req[0] = 1'b1; miss_paddr = 27'($urandom); miss_lru_way = 1'b1; miss_flags = 2'b11;
        @(posedge clk_core); #1;
        miss_req[0] = 1'b0; bus_gnt[0] = 1'b1;
        @(posedge clk_core); #1;
        bus_gnt[0] = 1'b0; bus_rvalid[0] = 1'b1; bus_rdata = $urandom;
        @(posedge clk_core); #1;
        bus_rdata = $urandom;
        @(posedge clk_core); #1;
        reset = 1'b1; bus_rdata = $urandom;
        @(posedge clk_core); #1;
        reset = 1'b0; bus_rdata = $urandom;
        @(negedge clk_core);
        checks++;
        if (outs(0) !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: got %h exp 0", outs(0));
        end
        @(posedge clk_core); #1;
        bus_rdata = $urandom;
        @(negedge clk_core);
        checks++;
        if ({cam_write_req[0], miss_busy[0]} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid late_beat write/busy: got %b%b exp 00", cam_write_req[0], miss_busy[0]);
        end
        @(posedge clk_core); #1;
        bus_rvalid[0] = 1'b0;
        run_refill("after_reset", 0, 27'($urandom), 1'b0, 2'b11, 0, 16'h0000, 4, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int sel, gd;
            logic [15:0] gp;
            sel = $urandom_range(0, 1);
            gd  = $urandom_range(0, sel ? 5 : 6);
            for (int i = 0; i < 4; i++) gp[4*i +: 4] = 4'($urandom_range(0, sel ? 5 : 3));
            run_refill($sformatf("rand%0d", n), sel, 27'($urandom), 1'($urandom), 2'($urandom), gd, gp,
                       (sel == 1 && $urandom_range(0, 3) == 0) ? 3 : 4,
                       int'($urandom_range(0, 5)) - 2, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset3();
        test_bus_error();
        test_stall();
        test_timeout();
        test_ignore_req();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
